// File: rtl/riscv_pkg.sv
// Shared constants for the hazard controller: opcodes, forward-select encodings, FSM states.
// Build option HAZARD_LOAD_FWD_EN: forward load data straight into X instead of stalling.
package riscv_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [1:0] FWD_RF   = 2'd0;
   localparam logic [1:0] FWD_ALU  = 2'd1;
   localparam logic [1:0] FWD_LOAD = 2'd2;

`ifdef HAZARD_LOAD_FWD_EN
   localparam logic LOAD_FWD_EN = 1'b1;
`else
   localparam logic LOAD_FWD_EN = 1'b0;
`endif

   typedef enum logic {
      RUN     = 1'b0,
      LDSTALL = 1'b1
   } hz_state_e;

   // Register fields are stored already masked: an unused source or a non-writing
   // destination is kept as x0, so a zero field can never produce a match.
   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       we;
      logic       load;
      logic       valid;
   } x_shadow_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       we;
      logic       load;
      logic       valid;
   } mw_shadow_t;

   // Without load forwarding a load producer in MW can never meet its consumer in X,
   // so the load path falls back to the register file rather than the ALU result.
   function automatic logic [1:0] fwd_sel(input logic match, input logic is_load);
      if (!match)
         return FWD_RF;
      else if (!is_load)
         return FWD_ALU;
      else
         return LOAD_FWD_EN ? FWD_LOAD : FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_decode.sv
// Register-usage decode of one RV32 instruction; x0 is folded into the use/write flags.
module hazard_decode
   import riscv_pkg::*;
(
   input  logic [31:0] inst,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        we,
   output logic        load
);

   logic [6:0] opc;

   assign opc = inst[6:0];
   assign rd  = inst[11:7];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];

   assign uses_rs1 = !(opc == LUI || opc == AUIPC || opc == JAL) && (rs1 != 5'd0);
   assign uses_rs2 = (opc == OP || opc == STORE || opc == BRANCH) && (rs2 != 5'd0);
   assign we       = !(opc == STORE || opc == BRANCH) && (rd != 5'd0);
   assign load     = (opc == LOAD);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: writeback bypass to D, X operand forwarding, load-use stall, flush.
// Build option HAZARD_LOAD_FWD_EN (see riscv_pkg) removes the load-use stall.
module hazard_ctrl
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_inst,
   input  logic        d_valid,
   input  logic        x_flush,
   input  logic        stall_ext,
   output logic        wb2d_a,
   output logic        wb2d_b,
   output logic [1:0]  x_fwd_a,
   output logic [1:0]  x_fwd_b,
   output logic        stall_d,
   output logic        kill_x,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic        dbg_state
);

   logic [4:0] d_rs1, d_rs2, d_rd;
   logic       d_uses_rs1, d_uses_rs2, d_we, d_load;

   hazard_decode u_dec (
      .inst     (d_inst),
      .rs1      (d_rs1),
      .rs2      (d_rs2),
      .rd       (d_rd),
      .uses_rs1 (d_uses_rs1),
      .uses_rs2 (d_uses_rs2),
      .we       (d_we),
      .load     (d_load)
   );

   hz_state_e  state;
   x_shadow_t  x_q;
   mw_shadow_t mw_q;
   logic [31:0] stall_cnt_q, flush_cnt_q;

   logic flush_acc, load_use, load_stall, stall_raw, kill_raw;
   logic mw_hit_a, mw_hit_b, x_hit_a, x_hit_b, d_hit_a, d_hit_b;

   // A flush seen while frozen is dropped; the branch still sits in X and re-asserts.
   assign flush_acc = x_flush & ~stall_ext;

   assign d_hit_a = d_uses_rs1 & (d_rs1 == x_q.rd);
   assign d_hit_b = d_uses_rs2 & (d_rs2 == x_q.rd);
   assign load_use = d_valid & x_q.valid & x_q.load & x_q.we & (x_q.rd != 5'd0)
                   & (d_hit_a | d_hit_b);
   assign load_stall = load_use & ~LOAD_FWD_EN & (state == RUN);

   // Flush wins over load-use: the dependent instruction in D is on the wrong path.
   assign stall_raw = load_stall & ~flush_acc;
   assign kill_raw  = flush_acc | load_stall;

   assign mw_hit_a = mw_q.valid & mw_q.we & d_uses_rs1 & (d_rs1 == mw_q.rd);
   assign mw_hit_b = mw_q.valid & mw_q.we & d_uses_rs2 & (d_rs2 == mw_q.rd);

   assign x_hit_a = x_q.valid & (x_q.rs1 != 5'd0) & mw_q.valid & mw_q.we
                  & (x_q.rs1 == mw_q.rd);
   assign x_hit_b = x_q.valid & (x_q.rs2 != 5'd0) & mw_q.valid & mw_q.we
                  & (x_q.rs2 == mw_q.rd);

   // Every output reads zero during the reset cycle, regardless of stored state.
   assign wb2d_a    = ~rst & mw_hit_a;
   assign wb2d_b    = ~rst & mw_hit_b;
   assign x_fwd_a   = rst ? FWD_RF : fwd_sel(x_hit_a, mw_q.load);
   assign x_fwd_b   = rst ? FWD_RF : fwd_sel(x_hit_b, mw_q.load);
   assign stall_d   = ~rst & stall_raw;
   assign kill_x    = ~rst & kill_raw;
   assign stall_cnt = rst ? 32'd0 : stall_cnt_q;
   assign flush_cnt = rst ? 32'd0 : flush_cnt_q;
   assign dbg_state = ~rst & (state == LDSTALL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         x_q         <= '0;
         mw_q        <= '0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall_raw || stall_ext)
            stall_cnt_q <= stall_cnt_q + 32'd1;

         if (!stall_ext) begin
            mw_q.rd    <= x_q.rd;
            mw_q.we    <= x_q.we;
            mw_q.load  <= x_q.load;
            mw_q.valid <= x_q.valid;

            if (kill_raw) begin
               x_q <= '0;
            end else begin
               x_q.rd    <= d_we ? d_rd : 5'd0;
               x_q.rs1   <= d_uses_rs1 ? d_rs1 : 5'd0;
               x_q.rs2   <= d_uses_rs2 ? d_rs2 : 5'd0;
               x_q.we    <= d_we;
               x_q.load  <= d_load;
               x_q.valid <= d_valid;
            end

            if (flush_acc)
               flush_cnt_q <= flush_cnt_q + 32'd1;

            // LDSTALL lasts exactly one unfrozen cycle: the load has moved to MW.
            if (state == LDSTALL || flush_acc)
               state <= RUN;
            else if (load_stall)
               state <= LDSTALL;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use stall, flush, external stall, reset.
module tb_hazard_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d_inst;
   logic        d_valid, x_flush, stall_ext;
   logic        wb2d_a, wb2d_b, stall_d, kill_x, dbg_state;
   logic [1:0]  x_fwd_a, x_fwd_b;
   logic [31:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .d_inst    (d_inst),
      .d_valid   (d_valid),
      .x_flush   (x_flush),
      .stall_ext (stall_ext),
      .wb2d_a    (wb2d_a),
      .wb2d_b    (wb2d_b),
      .x_fwd_a   (x_fwd_a),
      .x_fwd_b   (x_fwd_b),
      .stall_d   (stall_d),
      .kill_x    (kill_x),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] inst, input logic v);
      d_inst  = inst;
      d_valid = v;
   endtask

   task automatic bubble();
      put(32'd0, 1'b0);
   endtask

   function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, OP};
   endfunction

   function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'd0, rs1, 3'b010, rd, LOAD};
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      // reset overrides a pending flush and external stall
      rst = 1'b1; x_flush = 1'b1; stall_ext = 1'b1;
      put(r_add(5'd5, 5'd1, 5'd2), 1'b1);
      tick(); tick();
      check("rst_stall_d", {31'd0, stall_d}, 32'd0);
      check("rst_kill_x", {31'd0, kill_x}, 32'd0);
      check("rst_state", {31'd0, dbg_state}, 32'd0);
      check("rst_fwd_a", {30'd0, x_fwd_a}, 32'd0);
      rst = 1'b0; x_flush = 1'b0; stall_ext = 1'b0;
      bubble();
      #1;
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
      tick(); tick();

      // back-to-back ALU dependency forwards from MW
      put(r_add(5'd5, 5'd1, 5'd2), 1'b1);
      tick();
      put(r_add(5'd6, 5'd5, 5'd1), 1'b1);
      #1;
      check("alu_c1_fwd_a", {30'd0, x_fwd_a}, 32'd0);
      check("alu_c1_stall", {31'd0, stall_d}, 32'd0);
      tick();
      put(r_add(5'd7, 5'd1, 5'd6), 1'b1);
      #1;
      check("alu_c2_fwd_a", {30'd0, x_fwd_a}, 32'd1);
      check("alu_c2_fwd_b", {30'd0, x_fwd_b}, 32'd0);
      check("alu_c2_stall", {31'd0, stall_d}, 32'd0);
      check("alu_c2_kill", {31'd0, kill_x}, 32'd0);
      tick();
      bubble();
      #1;
      check("alu_c3_fwd_a", {30'd0, x_fwd_a}, 32'd0);
      check("alu_c3_fwd_b", {30'd0, x_fwd_b}, 32'd1);
      tick(); tick();

      // writeback bypass into D on rs2
      put(r_add(5'd9, 5'd1, 5'd2), 1'b1);
      tick();
      bubble();
      tick();
      put(r_add(5'd10, 5'd3, 5'd9), 1'b1);
      #1;
      check("wb_b", {31'd0, wb2d_b}, 32'd1);
      check("wb_a", {31'd0, wb2d_a}, 32'd0);
      bubble();
      tick(); tick();

      // x0 never forwards
      put(r_add(5'd0, 5'd1, 5'd2), 1'b1);
      tick();
      put(r_add(5'd3, 5'd0, 5'd0), 1'b1);
      tick();
      put(r_add(5'd4, 5'd0, 5'd0), 1'b1);
      #1;
      check("x0_fwd_a", {30'd0, x_fwd_a}, 32'd0);
      check("x0_fwd_b", {30'd0, x_fwd_b}, 32'd0);
      check("x0_wb_a", {31'd0, wb2d_a}, 32'd0);
      check("x0_wb_b", {31'd0, wb2d_b}, 32'd0);
      bubble();
      tick(); tick(); tick();

      // load-use
      put(i_lw(5'd5, 5'd1), 1'b1);
      tick();
      put(r_add(5'd6, 5'd5, 5'd1), 1'b1);
      #1;
`ifdef HAZARD_LOAD_FWD_EN
      check("lu_stall", {31'd0, stall_d}, 32'd0);
      check("lu_kill", {31'd0, kill_x}, 32'd0);
      tick();
      check("lu_fwd_a", {30'd0, x_fwd_a}, 32'd2);
      check("lu_state", {31'd0, dbg_state}, 32'd0);
      check("lu_stall_cnt", stall_cnt, 32'd0);
      bubble();
`else
      check("lu_stall", {31'd0, stall_d}, 32'd1);
      check("lu_kill", {31'd0, kill_x}, 32'd1);
      check("lu_state0", {31'd0, dbg_state}, 32'd0);
      tick();
      check("lu_stall2", {31'd0, stall_d}, 32'd0);
      check("lu_kill2", {31'd0, kill_x}, 32'd0);
      check("lu_wb_a", {31'd0, wb2d_a}, 32'd1);
      check("lu_state1", {31'd0, dbg_state}, 32'd1);
      check("lu_stall_cnt", stall_cnt, 32'd1);
      bubble();
      tick();
      check("lu_state2", {31'd0, dbg_state}, 32'd0);
      check("lu_fwd_a", {30'd0, x_fwd_a}, 32'd0);
      exp_stall = 1;
`endif
      tick(); tick();

      // flush in the same cycle as a load-use hazard
      put(i_lw(5'd5, 5'd1), 1'b1);
      tick();
      put(r_add(5'd6, 5'd5, 5'd1), 1'b1);
      x_flush = 1'b1;
      #1;
      check("fl_kill", {31'd0, kill_x}, 32'd1);
      check("fl_stall", {31'd0, stall_d}, 32'd0);
      tick();
      x_flush = 1'b0;
      bubble();
      #1;
      check("fl_state", {31'd0, dbg_state}, 32'd0);
      check("fl_flush_cnt", flush_cnt, 32'd1);
      check("fl_stall_cnt", stall_cnt, exp_stall);
      tick(); tick();

      // external stall held three cycles over a load-use hazard
      put(i_lw(5'd5, 5'd1), 1'b1);
      tick();
      put(r_add(5'd6, 5'd5, 5'd1), 1'b1);
      stall_ext = 1'b1;
      #1;
`ifdef HAZARD_LOAD_FWD_EN
      check("se_stall", {31'd0, stall_d}, 32'd0);
`else
      check("se_stall", {31'd0, stall_d}, 32'd1);
`endif
      tick();
      x_flush = 1'b1;
      tick();
      x_flush = 1'b0;
      tick();
      stall_ext = 1'b0;
      #1;
      check("se_stall_cnt", stall_cnt, exp_stall + 3);
      check("se_flush_cnt", flush_cnt, 32'd1);
      check("se_state", {31'd0, dbg_state}, 32'd0);
`ifdef HAZARD_LOAD_FWD_EN
      tick();
      check("se_fwd_a", {30'd0, x_fwd_a}, 32'd2);
      check("se_stall_cnt2", stall_cnt, exp_stall + 3);
`else
      check("se_stall_rel", {31'd0, stall_d}, 32'd1);
      check("se_kill_rel", {31'd0, kill_x}, 32'd1);
      tick();
      check("se_state2", {31'd0, dbg_state}, 32'd1);
      check("se_stall_cnt2", stall_cnt, exp_stall + 4);
      check("se_wb_a", {31'd0, wb2d_a}, 32'd1);
`endif

      // reset while in LDSTALL, dependent add still held in D
      rst = 1'b1;
      #1;
      check("mr_wb_a", {31'd0, wb2d_a}, 32'd0);
      check("mr_state", {31'd0, dbg_state}, 32'd0);
      check("mr_stall_cnt", stall_cnt, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("mr2_state", {31'd0, dbg_state}, 32'd0);
      check("mr2_stall", {31'd0, stall_d}, 32'd0);
      check("mr2_kill", {31'd0, kill_x}, 32'd0);
      check("mr2_wb_a", {31'd0, wb2d_a}, 32'd0);
      check("mr2_stall_cnt", stall_cnt, 32'd0);
      check("mr2_flush_cnt", flush_cnt, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
